// File: rtl/cba_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cba_pkg
// Purpose  : Default configuration constants for the pipelined carry-bypass
//            adder and a helper that reports whether a WIDTH / BLOCK /
//            PIPE_STAGES combination is legal.
// Revision : 1.0 - initial release
// ============================================================================
package cba_pkg;

  localparam int CBA_WIDTH       = 32;
  localparam int CBA_BLOCK       = 4;
  localparam int CBA_PIPE_STAGES = 2;

  // Legal when every segment splits evenly into whole bypass groups.
  function automatic bit cba_cfg_ok(input int width, input int block,
                                    input int stages);
    if (width < 1 || block < 1 || stages < 1) return 1'b0;
    return (width % (block * stages)) == 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cba_group.sv
`default_nettype none
// ============================================================================
// Module   : cba_group
// Purpose  : Combinational BLOCK-bit ripple group with carry bypass. When
//            every bit of the group propagates, the group carry-in is
//            forwarded straight to cout instead of waiting on the ripple.
// Ports    : a, b  - group operand bits
//            cin   - carry into the group
//            s     - group sum bits
//            cout  - carry out of the group
// Revision : 1.0 - initial release
// ============================================================================
module cba_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout
);

  logic [BLOCK:0] w_rc;
  logic           w_p;

  always_comb begin
    w_rc    = '0;
    s       = '0;
    w_rc[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]      = a[i] ^ b[i] ^ w_rc[i];
      w_rc[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & w_rc[i]);
    end
  end

  // All-propagate makes the ripple result equal to cin anyway; the mux just
  // gives the long chain a short path around the group.
  assign w_p  = &(a ^ b);
  assign cout = w_p ? cin : w_rc[BLOCK];

endmodule
`default_nettype wire

// File: rtl/pipelined_carry_bypass_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_carry_bypass_adder
// Purpose  : WIDTH-bit adder split into PIPE_STAGES register-separated
//            segments, each built from BLOCK-bit carry-bypass groups.
//            {c_out, sum} = in1 + in2 + c_in with valid/ready on both sides.
//            Optional macro CBA_SUB_EN adds the sub port (in1 + ~in2 + 1).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid / in_ready - operand handshake
//            in1, in2, c_in      - operands and carry-in
//            sub                 - subtract select (CBA_SUB_EN only)
//            out_valid/out_ready - result handshake
//            sum, c_out          - result and carry out of bit WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_carry_bypass_adder
  import cba_pkg::*;
#(
  parameter int WIDTH       = CBA_WIDTH,
  parameter int BLOCK       = CBA_BLOCK,
  parameter int PIPE_STAGES = CBA_PIPE_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
`ifdef CBA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int SEG    = WIDTH / PIPE_STAGES;
  localparam int GROUPS = SEG / BLOCK;

  if (!cba_cfg_ok(WIDTH, BLOCK, PIPE_STAGES)) begin : g_bad_cfg
    $error("pipelined_carry_bypass_adder: illegal WIDTH/BLOCK/PIPE_STAGES");
  end

  // Operand conditioning: subtraction folds into the adder as ~in2 + 1.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
`ifdef CBA_SUB_EN
  assign w_b_eff   = sub ? ~in2 : in2;
  assign w_cin_eff = sub ? 1'b1 : c_in;
`else
  assign w_b_eff   = in2;
  assign w_cin_eff = c_in;
`endif

  // Input rank: operands captured on the accepting edge.
  logic             r_iv;
  logic [WIDTH-1:0] r_ia;
  logic [WIDTH-1:0] r_ib;
  logic             r_ic;

  // Segment ranks: stage k holds sum bits of segments 0..k, the carry into
  // segment k+1 and the operand bits still waiting to be added.
  logic             r_v [PIPE_STAGES];
  logic [WIDTH-1:0] r_a [PIPE_STAGES];
  logic [WIDTH-1:0] r_b [PIPE_STAGES];
  logic [WIDTH-1:0] r_s [PIPE_STAGES];
  logic             r_c [PIPE_STAGES];

  logic [SEG-1:0]   w_seg_s  [PIPE_STAGES];
  logic             w_seg_co [PIPE_STAGES];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_seg
    logic [SEG-1:0] w_a;
    logic [SEG-1:0] w_b;
    logic [SEG-1:0] w_s;
    logic           w_ci;

    if (k == 0) begin : g_src_in
      assign w_a  = r_ia[0 +: SEG];
      assign w_b  = r_ib[0 +: SEG];
      assign w_ci = r_ic;
    end else begin : g_src_stage
      assign w_a  = r_a[k-1][k*SEG +: SEG];
      assign w_b  = r_b[k-1][k*SEG +: SEG];
      assign w_ci = r_c[k-1];
    end

    // Each group owns its carry nets so the chain is a set of distinct
    // signals rather than one self-referencing vector.
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      logic w_gci;
      logic w_gco;
      if (g == 0) begin : g_cin_seg
        assign w_gci = w_ci;
      end else begin : g_cin_prev
        assign w_gci = g_grp[g-1].w_gco;
      end
      cba_group #(.BLOCK(BLOCK)) u_group (
        .a    (w_a[g*BLOCK +: BLOCK]),
        .b    (w_b[g*BLOCK +: BLOCK]),
        .cin  (w_gci),
        .s    (w_s[g*BLOCK +: BLOCK]),
        .cout (w_gco)
      );
    end

    assign w_seg_s[k]  = w_s;
    assign w_seg_co[k] = g_grp[GROUPS-1].w_gco;
  end

  assign out_valid = r_v[PIPE_STAGES-1];
  assign sum       = r_s[PIPE_STAGES-1];
  assign c_out     = r_c[PIPE_STAGES-1];

  // Global lockstep stall: everything moves only when the output slot is
  // free or being drained this cycle.
  assign in_ready  = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iv <= 1'b0;
      r_ia <= '0;
      r_ib <= '0;
      r_ic <= 1'b0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
    end else if (in_ready) begin
      r_iv <= in_valid;
      if (in_valid) begin
        r_ia <= in1;
        r_ib <= w_b_eff;
        r_ic <= w_cin_eff;
      end
      r_v[0]            <= r_iv;
      r_a[0]            <= r_ia;
      r_b[0]            <= r_ib;
      r_s[0][0 +: SEG]  <= w_seg_s[0];
      r_c[0]            <= w_seg_co[0];
      for (int k = 1; k < PIPE_STAGES; k++) begin
        r_v[k]              <= r_v[k-1];
        r_a[k]              <= r_a[k-1];
        r_b[k]              <= r_b[k-1];
        r_s[k]              <= r_s[k-1];
        r_s[k][k*SEG +: SEG] <= w_seg_s[k];
        r_c[k]              <= w_seg_co[k];
      end
    end
  end

  // Operand copies in the last stage have no further consumer.
  logic w_unused;
  assign w_unused = ^{r_a[PIPE_STAGES-1], r_b[PIPE_STAGES-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_bypass_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_carry_bypass_adder
// Purpose  : Self-checking bench for pipelined_carry_bypass_adder. A queue
//            of arithmetic results is compared against the DUT output on
//            every valid cycle; directed cases pin literal results, latency,
//            stall behaviour and reset flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_carry_bypass_adder;

  localparam int W   = 32;
  localparam int BLK = 4;
  localparam int N   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         c_in;
  logic         sub_v;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [W:0] exp_q [$];

  always #5 clk = ~clk;

  pipelined_carry_bypass_adder #(
    .WIDTH       (W),
    .BLOCK       (BLK),
    .PIPE_STAGES (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .c_in      (c_in),
`ifdef CBA_SUB_EN
    .sub       (sub_v),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  // Reference: plain (W+1)-bit arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic ci, input logic sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic chk(input string nm, input logic [W:0] act,
                     input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard update on the clock edge (sees pre-edge DUT state).
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
`ifdef CBA_SUB_EN
        exp_q.push_back(model(in1, in2, c_in, sub_v));
`else
        exp_q.push_back(model(in1, in2, c_in, 1'b0));
`endif
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_rule", {{W{1'b0}}, in_ready},
          {{W{1'b0}}, (!out_valid || out_ready)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: got out_valid=1 expected no result pending");
        end else begin
          chk("result", {c_out, sum}, exp_q[0]);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci);
    int guard = 0;
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    c_in     = ci;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", (W+1)'(exp_q.size()), '0);
  endtask

  task automatic lat_test(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci,
                          input logic [W:0] exp_lit);
    out_ready = 1'b1;
    send(a, b, ci);
    in_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      chk({nm, "_early"}, {{W{1'b0}}, out_valid}, '0);
      @(negedge clk);
    end
    chk({nm, "_valid"}, {{W{1'b0}}, out_valid}, (W+1)'(1));
    chk({nm, "_value"}, {c_out, sum}, exp_lit);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int sent;
    logic [W:0] snap;

    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; c_in = 1'b0;
    sub_v = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    chk("rst_sum", {c_out, sum}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {{W{1'b0}}, in_ready}, (W+1)'(1));

    // Directed literal cases.
    lat_test("full_bypass", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0});
    lat_test("one_group", 32'h0000_000F, 32'h0, 1'b1, {1'b0, 32'h0000_0010});
    lat_test("half_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, {1'b0, 32'hFFFF_FFFF});
    lat_test("seg_cross", 32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h0001_0000});
`ifdef CBA_SUB_EN
    sub_v = 1'b1;
    lat_test("sub_5_7", 32'd5, 32'd7, 1'b0, {1'b0, 32'hFFFF_FFFE});
    lat_test("sub_7_5", 32'd7, 32'd5, 1'b0, {1'b1, 32'h0000_0002});
    sub_v = 1'b0;
`endif

    // Back-to-back random stream.
    base = n_out;
    for (int i = 0; i < 100; i++) begin
`ifdef CBA_SUB_EN
      sub_v = 1'($urandom_range(0, 1));
`endif
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    chk("stream_count", (W+1)'(n_out - base), (W+1)'(100));
    sub_v = 1'b0;

    // Fill with consumer blocked, then hold for 5 cycles.
    base = n_out;
    sent = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = 1'b1;
      in1 = W'($urandom);
      in2 = W'($urandom);
      c_in = 1'($urandom_range(0, 1));
      if (in_ready) sent++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stall_fill_count", (W+1)'(sent), (W+1)'(N + 1));
    snap = {c_out, sum};
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      chk("stall_in_ready", {{W{1'b0}}, in_ready}, '0);
      chk("stall_out_valid", {{W{1'b0}}, out_valid}, (W+1)'(1));
      chk("stall_hold", {c_out, sum}, snap);
    end
    out_ready = 1'b1;
    drain();
    chk("stall_delivered", (W+1)'(n_out - base), (W+1)'(sent));

    // Reset with two transfers in flight.
    base = n_out;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", {{W{1'b0}}, out_valid}, '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_flush_none", (W+1)'(n_out - base), '0);

    // Pipeline still healthy after flush.
    lat_test("post_rst", 32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_carry_bypass_adder.md
# pipelined_carry_bypass_adder

Parametrised, pipelined carry-bypass adder. Splits a WIDTH-bit addition into PIPE_STAGES register-separated segments. Each segment chains BLOCK-bit ripple groups whose carry-out bypasses the group when all bits propagate. Sits in the datapath wherever a wide add must close timing at full clock rate, with a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits
- BLOCK, 4, bits per bypass group
- PIPE_STAGES, 2, number of register-separated segments; latency in cycles

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- sub  input  1  subtract select; present only with CBA_SUB_EN
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result bits
- c_out  output  1  carry out of bit WIDTH-1

## Operation
- Legal configuration: WIDTH % (BLOCK*PIPE_STAGES) == 0 and PIPE_STAGES >= 1. Any other configuration is an elaboration error.
- SEG = WIDTH/PIPE_STAGES. Segment k adds bits [k*SEG +: SEG] using the registered carry from segment k-1. Segment 0 uses c_in.
- Within a segment, groups of BLOCK bits ripple internally:
  - P = &(a ^ b) over the group.
  - Group carry-out = P ? group carry-in : ripple carry-out.
- Arithmetic contract: {c_out, sum} = in1 + in2 + c_in, modulo 2^(WIDTH+1). The result is bit-exact regardless of BLOCK or PIPE_STAGES.
- Skew registers:
  - Operand bits for segments not yet computed travel with the pipeline.
  - Completed sum bits travel forward to the output stage.
- Each stage register carries a valid bit. Stage k holds the carry into segment k+1.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - in_ready = ~out_valid | out_ready.
  - When in_ready is 0, the whole pipeline holds: no register changes.
  - Bubbles advance and are not compressed. The pipeline is simple lockstep with a global stall.
- Operands are sampled only on an accepted transfer. in1/in2/c_in may change freely otherwise.

## Timing
- Reset values: all stage valids 0, out_valid 0, sum 0, c_out 0. in_ready reads 1 in the cycle after rst deasserts.
- Latency: an operand pair accepted at edge t appears on sum/c_out with out_valid=1 after edge t+PIPE_STAGES, provided there is no stall.
- Throughput: one result per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, sum/c_out/out_valid hold stable until accepted.
- Simultaneous accept in and accept out in the same cycle: legal, and no result is lost.
- rst mid-operation: all in-flight results are discarded, and no out_valid appears for them.
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.

## Configuration
- CBA_SUB_EN defined:
  - Port sub exists.
  - sub=1 computes in1 + ~in2 + 1. c_in is ignored, and c_out=1 means no borrow.
  - sub is sampled with the operands.
- CBA_SUB_EN undefined:
  - No sub port.
  - Behaviour is pure addition as above.

## Structure
- Package cba_pkg holds the default parameter constants (CBA_WIDTH, CBA_BLOCK, CBA_PIPE_STAGES) and a function that checks the legality of the configuration.
- Sub-module cba_group is a combinational BLOCK-bit ripple group with a bypass mux. Ports: a, b, cin, s, cout. The top instantiates SEG/BLOCK groups per segment via generate.

## Test plan
- Defaults, in1=32'hFFFF_FFFF, in2=32'h0000_0001, c_in=0 -> after 2 cycles sum=0, c_out=1. This exercises the full bypass chain.
- in1=32'h0000_000F, in2=0, c_in=1 -> sum=32'h0000_0010, c_out=0. Carry crosses only one group.
- Back-to-back stream of 100 random pairs with out_ready=1 -> one result per cycle, in order, matching the reference sum.
- out_ready held 0 for 5 cycles with pipeline full -> in_ready=0 and sum/out_valid stable. After release, all results are delivered in order with none lost.
- rst asserted with 2 transfers in flight -> out_valid=0 on the next cycle and no stale result later.
- With CBA_SUB_EN: sub=1, in1=5, in2=7 -> sum=32'hFFFF_FFFE, c_out=0. WIDTH=16, BLOCK=2, PIPE_STAGES=4 -> random check matches, latency 4.
